letter_sprite_addr_gen: RTL and testbench

- Upstream address generator for the VGA pixel path of the letter-typing game.
- Converts the VGA scan counters into the 17-bit ROM address and the glyph-select flag consumed by the pixel memory controller. That controller holds a 320x240 background ROM and an alphabet glyph ROM, muxed by the flag.
- Owns the falling-letter game state: spawn, per-frame fall, key hit/miss, score and lives.

---
 rtl/letter_game_pkg.sv | 10 +
 rtl/letter_sprite_addr_gen_lfsr16.sv | 11 +
 rtl/letter_sprite_addr_gen.sv | 110 +++++++++++
 tb/tb_letter_sprite_addr_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/letter_game_pkg.sv
// letter_game_pkg: shared FSM states and screen geometry for the letter-typing game.
package letter_game_pkg;
    typedef enum logic [2:0] {IDLE, SPAWN, FALL, HIT, MISS, OVER} state_t;
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int BG_W        = 320;
    localparam int SPRITE_PX   = 64;
    localparam int FALL_LIMIT  = V_ACTIVE - SPRITE_PX;
    localparam int NUM_LETTERS = 26;
endpackage

// File: rtl/letter_sprite_addr_gen_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);
    always_ff @(posedge clk)
        state <= rst ? SEED : {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
endmodule

// File: rtl/letter_sprite_addr_gen.sv
// letter_sprite_addr_gen: VGA ROM address/glyph-select generator plus falling-letter game state.
module letter_sprite_addr_gen
    import letter_game_pkg::*;
#(
    parameter int          FALL_STEP = 2,
    parameter int          LIVES     = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          GLYPH_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    input  logic        start,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic [16:0] pixel_addr,
    output logic        flag_alphabet,
    output logic [7:0]  score,
    output logic [1:0]  lives,
    output logic        game_over
);
    localparam logic [9:0] SPAN = 10'(2 * GLYPH_W);

    state_t      state, state_nx;
    logic [15:0] lfsr;
    logic [4:0]  letter, spawn_letter;
    logic [9:0]  x, y, y_step, spawn_x, dh, dv;
    logic        frame_tick, key_hit, show, sprite_hit, hit_d;
    logic [16:0] bg_addr, addr_nx;
    logic        unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .state(lfsr));

    assign unused_lfsr  = ^{lfsr[15:11], lfsr[7:5]};
    assign frame_tick   = v_cnt == 10'(V_ACTIVE) && h_cnt == 10'd0;
    assign key_hit      = key_valid && key_code == letter;
    assign y_step       = y + 10'(FALL_STEP);
    assign spawn_letter = lfsr[4:0] >= 5'(NUM_LETTERS) ? lfsr[4:0] - 5'(NUM_LETTERS) : lfsr[4:0];
    // lfsr[10:8]*80 split into *64 + *16
    assign spawn_x      = {1'b0, lfsr[10:8], 6'b0} + {3'b0, lfsr[10:8], 4'b0} + 10'd8;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? SPAWN : IDLE;
            SPAWN:   state_nx = frame_tick ? FALL : SPAWN;
            FALL:    state_nx = key_hit ? HIT : (frame_tick && y_step >= 10'(FALL_LIMIT)) ? MISS : FALL;
            HIT:     state_nx = SPAWN;
            MISS:    state_nx = lives == 2'd1 ? OVER : SPAWN;
            OVER:    state_nx = start ? SPAWN : OVER;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        game_over = state == OVER;
        show      = state == FALL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            letter <= '0;
            x      <= '0;
            y      <= '0;
            score  <= '0;
            lives  <= 2'(LIVES);
        end else begin
            if (state == SPAWN && frame_tick) begin
                letter <= spawn_letter;
                x      <= spawn_x;
                y      <= '0;
            end
            if (state == FALL && !key_hit && frame_tick)
                y <= y_step;
            if (state == FALL && key_hit && score != 8'hFF)
                score <= score + 8'd1;
            if (state == MISS)
                lives <= lives - 2'd1;
            if (state == OVER && start) begin
                score <= '0;
                lives <= 2'(LIVES);
            end
        end
    end

    // unsigned wrap makes counters left/above the sprite fail the span test
    assign dh         = h_cnt - x;
    assign dv         = v_cnt - y;
    assign sprite_hit = show && valid && dh < SPAN && dv < SPAN;
    // (v/2)*320 as (v/2)*256 + (v/2)*64
    assign bg_addr    = {v_cnt[9:1], 8'b0} + {2'b0, v_cnt[9:1], 6'b0} + {8'b0, h_cnt[9:1]};
    assign addr_nx    = sprite_hit ? {2'b0, letter, dv[5:1], dh[5:1]} : valid ? bg_addr : 17'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_addr    <= '0;
            hit_d         <= 1'b0;
            flag_alphabet <= 1'b0;
        end else begin
            pixel_addr    <= addr_nx;
            hit_d         <= sprite_hit;
            flag_alphabet <= hit_d;
        end
    end
endmodule

// File: tb/tb_letter_sprite_addr_gen.sv
// tb_letter_sprite_addr_gen: directed scoreboard bench for the letter sprite address generator and game FSM.
module tb_letter_sprite_addr_gen;
    import letter_game_pkg::*;

    logic        clk = 1'b0;
    logic        rst, valid, start, key_valid;
    logic [9:0]  h_cnt, v_cnt;
    logic [4:0]  key_code;
    logic [16:0] pixel_addr;
    logic        flag_alphabet, game_over;
    logic [7:0]  score;
    logic [1:0]  lives;

    int applied = 0;
    int errs = 0;
    logic [15:0] m_lfsr;
    int b_letter, b_x, b_y, m_score, m_lives;
    bit b_fall;
    int addr_q[$];
    bit flag_q[$];

    always #20 clk = ~clk;

    letter_sprite_addr_gen dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .start(start), .key_valid(key_valid), .key_code(key_code),
        .pixel_addr(pixel_addr), .flag_alphabet(flag_alphabet),
        .score(score), .lives(lives), .game_over(game_over)
    );

    always @(posedge clk)
        m_lfsr <= rst ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        applied++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int letter_of(input logic [15:0] l);
        int v = int'(l[4:0]);
        return v >= 26 ? v - 26 : v;
    endfunction

    function automatic int x_of(input logic [15:0] l);
        return int'(l[10:8]) * 80 + 8;
    endfunction

    function automatic bit mhit(input int h, input int v, input bit vld);
        return b_fall && vld && h >= b_x && h < b_x + 64 && v >= b_y && v < b_y + 64;
    endfunction

    function automatic int maddr(input int h, input int v, input bit vld);
        if (mhit(h, v, vld)) return b_letter * 1024 + ((v - b_y) / 2) * 32 + (h - b_x) / 2;
        return vld ? (v / 2) * 320 + h / 2 : 0;
    endfunction

    task automatic px(input int h, input int v, input bit vld, input string tag);
        @(negedge clk);
        h_cnt = 10'(h); v_cnt = 10'(v); valid = vld;
        addr_q.push_back(maddr(h, v, vld));
        flag_q.push_back(mhit(h, v, vld));
        @(posedge clk); #1;
        chk({tag, "_addr"}, 32'(pixel_addr), 32'(addr_q.pop_front()));
        if (flag_q.size() == 2) chk({tag, "_flag"}, 32'(flag_alphabet), 32'(flag_q.pop_front()));
    endtask

    task automatic px_end();
        px(0, 0, 1'b0, "flush");
        flag_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic key(input int code);
        @(negedge clk); key_valid = 1'b1; key_code = 5'(code);
        if (b_fall && code == b_letter) begin
            b_fall = 1'b0;
            if (m_score < 255) m_score++;
        end
        @(posedge clk); #1; key_valid = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk); v_cnt = 10'd480; h_cnt = 10'd0; valid = 1'b0;
        if (b_fall) begin
            b_y += 2;
            if (b_y >= 416) b_fall = 1'b0;
        end
        @(posedge clk); #1; v_cnt = 10'd0;
    endtask

    // waits (bounded) until the bench LFSR would produce the wanted spawn, then issues the frame tick
    task automatic spawn(input int want_l, input int want_x);
        bit ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            ok = (want_l < 0 || letter_of(m_lfsr) == want_l) && (want_x < 0 || x_of(m_lfsr) == want_x);
        end
        if (!ok) begin
            applied++;
            errs++;
            $display("FAIL spawn_search: no LFSR match for letter %0d x %0d", want_l, want_x);
        end
        b_letter = letter_of(m_lfsr); b_x = x_of(m_lfsr); b_y = 0; b_fall = 1'b1;
        v_cnt = 10'd480; h_cnt = 10'd0; valid = 1'b0;
        @(posedge clk); #1; v_cnt = 10'd0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; start = 1'b0; key_valid = 1'b0;
        h_cnt = '0; v_cnt = '0; key_code = '0;
        b_fall = 1'b0; m_score = 0; m_lives = 3;
        idle(3);
        chk("rst_addr", 32'(pixel_addr), 0);
        chk("rst_flag", 32'(flag_alphabet), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_lives", 32'(lives), 3);
        chk("rst_over", 32'(game_over), 0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;

        px(639, 479, 1'b1, "bg_max");
        px(0, 0, 1'b1, "bg_origin");
        px(101, 51, 1'b1, "bg_mid");
        px(200, 300, 1'b0, "bg_invalid");
        px_end();

        key(0);
        chk("idle_key_state", 32'(dut.state), 32'(IDLE));
        chk("idle_key_score", 32'(score), 0);
        pulse_start();
        chk("start_spawn", 32'(dut.state), 32'(SPAWN));
        pulse_start();
        chk("spawn_start_ign", 32'(dut.state), 32'(SPAWN));
        key(0);
        chk("spawn_key_ign", 32'(score), 0);

        spawn(2, 88);
        chk("fall_state", 32'(dut.state), 32'(FALL));
        chk("spawn_letter", 32'(dut.letter), 2);
        chk("spawn_x", 32'(dut.x), 88);
        repeat (50) tick();
        chk("fall_y100", 32'(dut.y), 100);
        px(90, 103, 1'b1, "spr_inner");
        px(88, 100, 1'b1, "spr_corner");
        px(151, 163, 1'b1, "spr_far");
        px(152, 163, 1'b1, "spr_right_out");
        px(87, 100, 1'b1, "spr_left_out");
        px(88, 164, 1'b1, "spr_below_out");
        px(88, 99, 1'b1, "spr_above_out");
        px(120, 130, 1'b0, "spr_invalid");
        px_end();

        key(3);
        chk("miskey_state", 32'(dut.state), 32'(FALL));
        chk("miskey_score", 32'(score), 0);
        pulse_start();
        chk("fall_start_ign", 32'(dut.state), 32'(FALL));
        key(2);
        chk("hit_state", 32'(dut.state), 32'(HIT));
        chk("hit_score", 32'(score), 32'(m_score));
        idle(1);
        chk("hit_respawn", 32'(dut.state), 32'(SPAWN));

        spawn(7, -1);
        key(6);
        chk("key6_score", 32'(score), 32'(m_score));
        chk("key6_state", 32'(dut.state), 32'(FALL));
        key(7);
        chk("key7_state", 32'(dut.state), 32'(HIT));
        chk("key7_score", 32'(score), 32'(m_score));
        idle(1);

        while (m_score < 255) begin
            spawn(-1, -1);
            key(b_letter);
            idle(1);
        end
        chk("score_255", 32'(score), 255);
        spawn(-1, -1);
        key(b_letter);
        chk("score_sat", 32'(score), 32'(m_score));
        idle(1);

        spawn(-1, -1);
        repeat (207) tick();
        chk("simul_y414", 32'(dut.y), 414);
        @(negedge clk);
        key_valid = 1'b1; key_code = 5'(b_letter); v_cnt = 10'd480; h_cnt = 10'd0;
        b_fall = 1'b0;
        @(posedge clk); #1; key_valid = 1'b0; v_cnt = 10'd0;
        chk("simul_hit", 32'(dut.state), 32'(HIT));
        chk("simul_lives", 32'(lives), 32'(m_lives));
        idle(1);

        for (int k = 0; k < 3; k++) begin
            spawn(-1, -1);
            repeat (208) tick();
            chk("miss_state", 32'(dut.state), 32'(MISS));
            idle(1);
            m_lives--;
            chk("miss_lives", 32'(lives), 32'(m_lives));
            chk("miss_next", 32'(dut.state), m_lives == 0 ? 32'(OVER) : 32'(SPAWN));
        end
        chk("over_flag", 32'(game_over), 1);
        key(0);
        chk("over_key_ign", 32'(score), 32'(m_score));
        pulse_start();
        m_score = 0; m_lives = 3;
        chk("restart_score", 32'(score), 0);
        chk("restart_lives", 32'(lives), 3);
        chk("restart_state", 32'(dut.state), 32'(SPAWN));
        chk("restart_over", 32'(game_over), 0);

        spawn(-1, -1);
        key(b_letter);
        chk("pre_rst_score", 32'(score), 1);
        idle(1);
        spawn(-1, -1);
        repeat (10) tick();
        px(b_x + 4, b_y + 4, 1'b1, "pre_rst_spr");
        @(negedge clk);
        rst = 1'b1; valid = 1'b1; h_cnt = 10'(b_x + 6); v_cnt = 10'(b_y + 6);
        @(posedge clk); #1;
        chk("mid_rst_addr", 32'(pixel_addr), 0);
        chk("mid_rst_flag", 32'(flag_alphabet), 0);
        chk("mid_rst_score", 32'(score), 0);
        chk("mid_rst_lives", 32'(lives), 3);
        chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
        chk("mid_rst_letter", 32'(dut.letter), 0);
        chk("mid_rst_x", 32'(dut.x), 0);
        chk("mid_rst_y", 32'(dut.y), 0);
        rst = 1'b0;
        b_fall = 1'b0;
        addr_q.delete();
        flag_q.delete();
        px(b_x + 4, b_y + 4, 1'b0, "post_rst_invalid");
        px(10, 10, 1'b1, "post_rst_bg");
        px(20, 20, 1'b1, "post_rst_bg2");
        px_end();

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end
endmodule
